// File: rtl/mem_responder.sv
// ============================================================================
// mem_responder: req/valid memory responder with a word RAM, an I/O register
// window at IO_MEM and a programmable number of wait states per access.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_responder #(
    parameter int               WIDTH       = 16,
    parameter int               ADDR_BITS   = 8,
    parameter int               WAIT_CYCLES = 2,
    parameter logic [WIDTH-1:0] IO_MEM      = 16'hCFFD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             we,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0] io_in,
    output logic             ready,
    output logic             valid,
    output logic             err,
    output logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] io_out
);

    localparam logic [1:0]       S_IDLE     = 2'd0;
    localparam logic [1:0]       S_WAIT     = 2'd1;
    localparam logic [1:0]       S_DONE     = 2'd2;
    localparam logic [WIDTH-1:0] C_IO_IN    = IO_MEM + WIDTH'(1);
    localparam logic [3:0]       C_CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic [3:0]           r_cnt;
    logic [WIDTH-1:0]     r_addr;
    logic [WIDTH-1:0]     r_wdata;
    logic                 r_we;
    logic                 r_err;
    logic [WIDTH-1:0]     r_rdata;
    logic [WIDTH-1:0]     r_io_out;
    logic [WIDTH-1:0]     r_sync1;
    logic [WIDTH-1:0]     r_sync2;
    logic [WIDTH-1:0]     r_ram [0:(2**ADDR_BITS)-1];

    logic                 w_accept;
    logic                 w_commit;
    logic [WIDTH-1:0]     w_c_addr;
    logic [WIDTH-1:0]     w_c_wdata;
    logic                 w_c_we;
    logic                 w_is_ram;
    logic                 w_is_io_out;
    logic                 w_is_io_in;
    logic                 w_is_unmapped;
    logic [ADDR_BITS-1:0] w_idx;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_next_state = (WAIT_CYCLES > 0) ? S_WAIT : S_DONE;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ready = (r_state == S_IDLE);
        valid = (r_state == S_DONE);
        err   = (r_state == S_DONE) && r_err;
    end

    // With zero wait states the commit happens on the accept edge itself,
    // so the live request is used instead of the not-yet-latched copy.
    always_comb begin
        w_accept      = (r_state == S_IDLE) && req;
        w_commit      = (w_next_state == S_DONE);
        w_c_addr      = w_accept ? addr  : r_addr;
        w_c_wdata     = w_accept ? wdata : r_wdata;
        w_c_we        = w_accept ? we    : r_we;
        w_is_ram      = (w_c_addr < IO_MEM);
        w_is_io_out   = (w_c_addr == IO_MEM);
        w_is_io_in    = (w_c_addr == C_IO_IN);
        w_is_unmapped = !w_is_ram && !w_is_io_out && !w_is_io_in;
        w_idx         = w_c_addr[ADDR_BITS-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= 4'd0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_we     <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            r_io_out <= '0;
            r_sync1  <= '0;
            r_sync2  <= '0;
        end else begin
            r_sync1 <= io_in;
            r_sync2 <= r_sync1;
            r_err   <= w_commit && w_is_unmapped;
            if (w_accept) begin
                r_addr  <= addr;
                r_wdata <= wdata;
                r_we    <= we;
                r_cnt   <= C_CNT_LOAD;
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit) begin
                if (w_c_we) begin
                    if (w_is_io_out) begin
                        r_io_out <= w_c_wdata;
                    end
                end else begin
                    if (w_is_ram) begin
                        r_rdata <= r_ram[w_idx];
                    end else if (w_is_io_out) begin
                        r_rdata <= r_io_out;
                    end else if (w_is_io_in) begin
                        r_rdata <= r_sync2;
                    end else begin
                        r_rdata <= '0;
                    end
                end
            end
        end
    end

    // RAM contents survive reset; a reset mid-access prevents the commit edge.
    always_ff @(posedge clk) begin
        if (w_commit && w_c_we && w_is_ram) begin
            r_ram[w_idx] <= w_c_wdata;
        end
    end

    assign rdata  = r_rdata;
    assign io_out = r_io_out;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// tb_mem_responder: directed self-checking bench for mem_responder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_responder;

    logic        clk;
    logic        reset;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] io_in;
    logic        ready;
    logic        valid;
    logic        err;
    logic [15:0] rdata;
    logic [15:0] io_out;

    int total = 0;
    int bad   = 0;

    mem_responder #(
        .WIDTH      (16),
        .ADDR_BITS  (8),
        .WAIT_CYCLES(2),
        .IO_MEM     (16'hCFFD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .io_in (io_in),
        .ready (ready),
        .valid (valid),
        .err   (err),
        .rdata (rdata),
        .io_out(io_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one access from IDLE and returns at the negedge of the valid cycle.
    // lat counts cycles after the accept edge; nrdy counts ready-low cycles.
    task automatic do_access(input logic iwe, input logic [15:0] ia, input logic [15:0] iw,
                             output int lat, output int nrdy);
        @(negedge clk);
        req = 1'b1; we = iwe; addr = ia; wdata = iw;
        nrdy = 0;
        @(negedge clk);
        req = 1'b0;
        lat = 1;
        while (valid !== 1'b1 && lat < 20) begin
            if (ready === 1'b0) nrdy++;
            @(negedge clk);
            lat++;
        end
        if (ready === 1'b0) nrdy++;
    endtask

    task automatic test_reset;
        reset = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; io_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({ready, valid, err, rdata, io_out} !== {3'b100, 16'h0000, 16'h0000}) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got rdy=%b vld=%b err=%b rdata=%h io_out=%h want 1 0 0 0000 0000",
                         i, ready, valid, err, rdata, io_out);
            end
        end
    endtask

    task automatic test_write_read;
        int lat, nrdy;
        do_access(1'b1, 16'h0010, 16'hBEEF, lat, nrdy);
        total++;
        if (lat !== 3 || nrdy !== 3) begin
            bad++; $display("FAIL wr_latency got lat=%0d nrdy=%0d want 3 3", lat, nrdy);
        end
        total++;
        if (rdata !== 16'h0000 || err !== 1'b0) begin
            bad++; $display("FAIL wr_no_rdata got rdata=%h err=%b want 0000 0", rdata, err);
        end
        @(negedge clk);
        total++;
        if (valid !== 1'b0 || ready !== 1'b1) begin
            bad++; $display("FAIL valid_one_cycle got vld=%b rdy=%b want 0 1", valid, ready);
        end
        do_access(1'b0, 16'h0010, 16'h0000, lat, nrdy);
        total++;
        if (lat !== 3 || nrdy !== 3 || rdata !== 16'hBEEF) begin
            bad++; $display("FAIL rd_beef got lat=%0d nrdy=%0d rdata=%h want 3 3 beef", lat, nrdy, rdata);
        end
    endtask

    task automatic test_alias;
        int lat, nrdy;
        do_access(1'b1, 16'h0105, 16'h1234, lat, nrdy);
        do_access(1'b0, 16'h0005, 16'h0000, lat, nrdy);
        total++;
        if (rdata !== 16'h1234) begin
            bad++; $display("FAIL alias_read got %h want 1234", rdata);
        end
        do_access(1'b1, 16'h0005, 16'h0000, lat, nrdy);
        total++;
        if (rdata !== 16'h1234) begin
            bad++; $display("FAIL alias_write_keeps_rdata got %h want 1234", rdata);
        end
        do_access(1'b0, 16'h0105, 16'hFFFF, lat, nrdy);
        total++;
        if (rdata !== 16'h0000) begin
            bad++; $display("FAIL alias_reread got %h want 0000", rdata);
        end
    endtask

    task automatic test_io;
        int lat, nrdy;
        io_in = 16'h5A5A;
        do_access(1'b1, 16'hCFFD, 16'h00A5, lat, nrdy);
        total++;
        if (io_out !== 16'h00A5 || err !== 1'b0) begin
            bad++; $display("FAIL io_out_write got io_out=%h err=%b want 00a5 0", io_out, err);
        end
        do_access(1'b0, 16'hCFFD, 16'h0000, lat, nrdy);
        total++;
        if (rdata !== 16'h00A5) begin
            bad++; $display("FAIL io_out_read got %h want 00a5", rdata);
        end
        do_access(1'b0, 16'hCFFE, 16'h0000, lat, nrdy);
        total++;
        if (rdata !== 16'h5A5A || err !== 1'b0) begin
            bad++; $display("FAIL io_in_read got rdata=%h err=%b want 5a5a 0", rdata, err);
        end
        do_access(1'b1, 16'hCFFE, 16'h1111, lat, nrdy);
        total++;
        if (err !== 1'b0 || io_out !== 16'h00A5 || rdata !== 16'h5A5A) begin
            bad++; $display("FAIL io_in_write got err=%b io_out=%h rdata=%h want 0 00a5 5a5a", err, io_out, rdata);
        end
        do_access(1'b0, 16'hD000, 16'h0000, lat, nrdy);
        total++;
        if (rdata !== 16'h0000 || err !== 1'b1 || valid !== 1'b1) begin
            bad++; $display("FAIL unmapped_read got rdata=%h err=%b vld=%b want 0000 1 1", rdata, err, valid);
        end
        @(negedge clk);
        total++;
        if (err !== 1'b0) begin
            bad++; $display("FAIL err_one_cycle got %b want 0", err);
        end
        do_access(1'b1, 16'hFFFF, 16'h2222, lat, nrdy);
        total++;
        if (err !== 1'b1 || io_out !== 16'h00A5) begin
            bad++; $display("FAIL unmapped_write got err=%b io_out=%h want 1 00a5", err, io_out);
        end
    endtask

    task automatic test_handshake;
        int lat, nrdy;
        do_access(1'b1, 16'h0030, 16'h0777, lat, nrdy);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 16'h0020; wdata = 16'h1111;
        @(negedge clk);
        req = 1'b0; addr = 16'h0030; wdata = 16'h2222; we = 1'b1;
        @(negedge clk);
        req = 1'b1; addr = 16'h0031; wdata = 16'h3333;
        @(negedge clk);
        total++;
        if (valid !== 1'b1) begin
            bad++; $display("FAIL hs_valid_timing got %b want 1", valid);
        end
        req = 1'b0;
        do_access(1'b0, 16'h0020, 16'h0000, lat, nrdy);
        total++;
        if (rdata !== 16'h1111) begin
            bad++; $display("FAIL hs_latched_write got %h want 1111", rdata);
        end
        do_access(1'b0, 16'h0030, 16'h0000, lat, nrdy);
        total++;
        if (rdata !== 16'h0777) begin
            bad++; $display("FAIL hs_other_untouched got %h want 0777", rdata);
        end
    endtask

    task automatic test_back_to_back;
        int nvalid;
        nvalid = 0;
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 16'h0020;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (valid === 1'b1) nvalid++;
            total++;
            if (valid !== ((i % 4) == 3)) begin
                bad++; $display("FAIL b2b_valid cyc=%0d got %b want %b", i, valid, ((i % 4) == 3));
            end
        end
        req = 1'b0;
        total++;
        if (nvalid !== 4 || rdata !== 16'h1111) begin
            bad++; $display("FAIL b2b_count got n=%0d rdata=%h want 4 1111", nvalid, rdata);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int lat, nrdy;
        int vseen;
        do_access(1'b1, 16'h00FD, 16'h4321, lat, nrdy);
        do_access(1'b1, 16'hCFFD, 16'h0000, lat, nrdy);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 16'hCFFD; wdata = 16'hFFFF;
        @(negedge clk);
        req = 1'b0;
        reset = 1'b0;
        #1;
        total++;
        if (ready !== 1'b1 || valid !== 1'b0 || io_out !== 16'h0000 || rdata !== 16'h0000) begin
            bad++; $display("FAIL mid_reset_async got rdy=%b vld=%b io_out=%h rdata=%h want 1 0 0000 0000",
                            ready, valid, io_out, rdata);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        vseen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (valid !== 1'b0 || io_out !== 16'h0000 || ready !== 1'b1) vseen++;
        end
        total++;
        if (vseen !== 0) begin
            bad++; $display("FAIL mid_reset_abort got bad_cycles=%0d want 0", vseen);
        end
        do_access(1'b0, 16'h00FD, 16'h0000, lat, nrdy);
        total++;
        if (rdata !== 16'h4321 || io_out !== 16'h0000) begin
            bad++; $display("FAIL mid_reset_ram got rdata=%h io_out=%h want 4321 0000", rdata, io_out);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_alias();
        test_io();
        test_handshake();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
